// File: rtl/mig_port_arbiter.sv
// mig_port_arbiter: round-robin sharing of one MIG port between two read requesters and one write requester.
// Optional watchdog abort is compiled in when MIG_ARB_TIMEOUT_EN is defined.
module mig_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 1024,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [2:0]                  req_valid_i,
  input  logic [2:0][ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [2:0][7:0]             req_len_i,
  output logic [2:0]                  req_ready_o,
  output logic [DATA_WIDTH-1:0]       rd_data_o,
  output logic [1:0]                  rd_valid_o,
  output logic                        rd_last_o,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  output logic [2:0]                  done_o,
  output logic                        err_o,
  output logic [ADDR_WIDTH-1:0]       mig_addr,
  output logic                        mig_arvalid,
  output logic                        mig_awvalid,
  input  logic                        mig_arready,
  input  logic                        mig_awready,
  output logic [7:0]                  mig_arwlen,
  input  logic [DATA_WIDTH-1:0]       mig_data,
  input  logic                        mig_data_valid,
  input  logic                        mig_rw_last,
  output logic [DATA_WIDTH-1:0]       mig_wdata,
  output logic                        mig_wvalid,
  input  logic                        mig_wready,
  output logic [DATA_WIDTH/8-1:0]     mig_wstrb,
  output logic                        mig_wlast,
  input  logic                        mig_bvalid,
  output logic                        mig_bready
);
  typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_t;
  state_t state, state_nx;
  logic [1:0] grant, last_grant, p0, p1, p2, sel;
  logic [7:0] beat;
  logic take, tmo;
  function automatic logic [1:0] nxt(input logic [1:0] x);
    return x == 2'd2 ? 2'd0 : x + 2'd1;
  endfunction
  assign p0   = nxt(last_grant);
  assign p1   = nxt(p0);
  assign p2   = nxt(p1);
  assign sel  = req_valid_i[p0] ? p0 : req_valid_i[p1] ? p1 : p2;
  assign take = state == IDLE && |req_valid_i && !reset_i;
  assign req_ready_o = take ? 3'b001 << sel : 3'b000;
  assign mig_arvalid = state == ADDR && grant != 2'd2 && !tmo;
  assign mig_awvalid = state == ADDR && grant == 2'd2 && !tmo;
  assign rd_data_o   = mig_data;
  assign rd_last_o   = state == RDATA && mig_data_valid && mig_rw_last && !tmo;
  assign rd_valid_o  = state == RDATA && mig_data_valid && !tmo ? 2'b01 << grant[0] : 2'b00;
  assign mig_wdata   = wr_data_i;
  assign mig_wstrb   = '1;
  assign mig_wvalid  = state == WDATA && wr_valid_i && !tmo;
  assign wr_ready_o  = state == WDATA && mig_wready;
  assign mig_wlast   = state == WDATA && beat == mig_arwlen && !tmo;
  assign mig_bready  = 1'b1;
  assign done_o      = rd_last_o ? 3'b001 << grant : state == WRESP && mig_bvalid && !tmo ? 3'b100 : 3'b000;
  // state register
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_nx;
  // next state: one outstanding transaction, any timeout returns to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |req_valid_i ? ADDR : IDLE;
      ADDR:    state_nx = mig_arvalid && mig_arready ? RDATA : mig_awvalid && mig_awready ? WDATA : ADDR;
      RDATA:   state_nx = rd_last_o ? IDLE : RDATA;
      WDATA:   state_nx = mig_wvalid && mig_wready && mig_wlast ? WRESP : WDATA;
      WRESP:   state_nx = mig_bvalid ? IDLE : WRESP;
      default: state_nx = IDLE;
    endcase
    if (tmo) state_nx = IDLE;
  end
  // grant bookkeeping, command latch and write beat counter (8-bit, wraps after a 256-beat burst)
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      grant      <= 2'd0;
      last_grant <= 2'd2;
      mig_addr   <= '0;
      mig_arwlen <= 8'd0;
      beat       <= 8'd0;
    end else if (take) begin
      grant      <= sel;
      last_grant <= sel;
      mig_addr   <= req_addr_i[sel];
      mig_arwlen <= req_len_i[sel] - 8'd1;
      beat       <= 8'd0;
    end else if (mig_wvalid && mig_wready) beat <= beat + 8'd1;
`ifdef MIG_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic hs;
  assign hs = (state == RDATA && mig_data_valid) || (state == WDATA && mig_wvalid && mig_wready) ||
              (state == WRESP && mig_bvalid);
  assign tmo   = state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign err_o = tmo;
  // watchdog: restarts on progress, counts idle cycles of an open transaction
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) tmo_cnt <= '0;
    else tmo_cnt <= state_nx != state || hs ? '0 : state != IDLE ? tmo_cnt + 1'b1 : tmo_cnt;
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mig_port_arbiter.sv
// tb_mig_port_arbiter: directed checks of arbitration order, read/write bursts, length boundaries and reset.
module tb_mig_port_arbiter;
  logic clk_i = 1'b0, reset_i = 1'b1;
  logic [2:0] req_valid_i = '0;
  logic [2:0][31:0] req_addr_i = '0;
  logic [2:0][7:0] req_len_i = '0;
  logic [2:0] req_ready_o, done_o;
  logic [63:0] rd_data_o, wr_data_i = '0, mig_data = '0, mig_wdata;
  logic [1:0] rd_valid_o;
  logic rd_last_o, wr_valid_i = 1'b0, wr_ready_o, err_o;
  logic [31:0] mig_addr;
  logic mig_arvalid, mig_awvalid, mig_arready = 1'b0, mig_awready = 1'b0;
  logic [7:0] mig_arwlen, mig_wstrb;
  logic mig_data_valid = 1'b0, mig_rw_last = 1'b0, mig_wvalid, mig_wready = 1'b0, mig_wlast;
  logic mig_bvalid = 1'b0, mig_bready;
  int n_run = 0, n_fail = 0;
  mig_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_len_i(req_len_i), .req_ready_o(req_ready_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .rd_last_o(rd_last_o), .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .done_o(done_o), .err_o(err_o), .mig_addr(mig_addr), .mig_arvalid(mig_arvalid),
    .mig_awvalid(mig_awvalid), .mig_arready(mig_arready), .mig_awready(mig_awready),
    .mig_arwlen(mig_arwlen), .mig_data(mig_data), .mig_data_valid(mig_data_valid),
    .mig_rw_last(mig_rw_last), .mig_wdata(mig_wdata), .mig_wvalid(mig_wvalid), .mig_wready(mig_wready),
    .mig_wstrb(mig_wstrb), .mig_wlast(mig_wlast), .mig_bvalid(mig_bvalid), .mig_bready(mig_bready)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // full transaction for requester g, entered in the IDLE cycle where g should be granted
  task automatic txn(input int g, input int len, input int dly, input bit hold);
    int n = len == 0 ? 256 : len;
    bit rd = g != 2;
    #1 chk("grant", 64'(req_ready_o), 64'(3'b001 << g));
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk_i);
      if (i == 0 && !hold) req_valid_i[g] = 1'b0;
      mig_arready = rd && i == dly;
      mig_awready = !rd && i == dly;
      #1;
      chk(rd ? "arvalid" : "awvalid", 64'(rd ? mig_arvalid : mig_awvalid), 64'd1);
      chk("arwlen", 64'(mig_arwlen), 64'(n - 1));
      chk("addr", 64'(mig_addr), 64'(req_addr_i[g]));
    end
    @(negedge clk_i);
    mig_arready = 1'b0;
    mig_awready = 1'b0;
    for (int b = 0; b < n; b++) begin
      if (rd) begin
        mig_data_valid = 1'b1;
        mig_rw_last = b == n - 1;
        mig_data = 64'hD000 + 64'(b);
        #1;
        chk("rd_valid", 64'(rd_valid_o), 64'(2'b01 << g));
        chk("rd_data", rd_data_o, 64'hD000 + 64'(b));
        chk("rd_last", 64'(rd_last_o), 64'(b == n - 1));
        chk("rd_done", 64'(done_o), b == n - 1 ? 64'(3'b001 << g) : 64'd0);
      end else begin
        wr_valid_i = 1'b1;
        mig_wready = 1'b1;
        wr_data_i = 64'hE000 + 64'(b);
        #1;
        chk("wvalid", 64'(mig_wvalid), 64'd1);
        chk("wlast", 64'(mig_wlast), 64'(b == n - 1));
      end
      @(negedge clk_i);
    end
    mig_data_valid = 1'b0;
    mig_rw_last = 1'b0;
    wr_valid_i = 1'b0;
    mig_wready = 1'b0;
    if (!rd) begin
      mig_bvalid = 1'b1;
      #1 chk("bready", 64'(mig_bready), 64'd1);
      chk("wr_done", 64'(done_o), 64'b100);
      @(negedge clk_i);
      mig_bvalid = 1'b0;
    end
  endtask
  initial begin
    #200000 $display("FAIL watchdog: run got stuck expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    req_addr_i[0] = 32'h1000;
    req_addr_i[1] = 32'h3000;
    req_addr_i[2] = 32'h2000;
    req_valid_i = 3'b001;
    @(negedge clk_i);
    #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_arvalid", 64'(mig_arvalid), 64'd0);
    chk("rst_addr", 64'(mig_addr), 64'd0);
    chk("rst_arwlen", 64'(mig_arwlen), 64'd0);
    chk("rst_bready", 64'(mig_bready), 64'd1);
    chk("rst_err", 64'(err_o), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    req_len_i[0] = 8'd4;
    txn(0, 4, 2, 1'b0);
    req_valid_i = 3'b100;
    req_len_i[2] = 8'd2;
    #1 chk("w_grant", 64'(req_ready_o), 64'b100);
    @(negedge clk_i);
    req_valid_i = 3'b000;
    wr_valid_i = 1'b1;
    mig_awready = 1'b1;
    #1;
    chk("w_awvalid", 64'(mig_awvalid), 64'd1);
    chk("w_arvalid", 64'(mig_arvalid), 64'd0);
    chk("w_arwlen", 64'(mig_arwlen), 64'd1);
    chk("w_wvalid_addr", 64'(mig_wvalid), 64'd0);
    @(negedge clk_i);
    mig_awready = 1'b0;
    mig_wready = 1'b1;
    wr_data_i = 64'hAA;
    #1;
    chk("w_awvalid_off", 64'(mig_awvalid), 64'd0);
    chk("w_wlast0", 64'(mig_wlast), 64'd0);
    chk("w_wready0", 64'(wr_ready_o), 64'd1);
    chk("w_wdata", mig_wdata, 64'hAA);
    chk("w_wstrb", 64'(mig_wstrb), 64'hFF);
    @(negedge clk_i);
    mig_wready = 1'b0;
    wr_data_i = 64'hBB;
    #1;
    chk("w_wlast1_stall", 64'(mig_wlast), 64'd1);
    chk("w_wready_stall", 64'(wr_ready_o), 64'd0);
    @(negedge clk_i);
    mig_wready = 1'b1;
    #1;
    chk("w_wlast1", 64'(mig_wlast), 64'd1);
    chk("w_done_early", 64'(done_o), 64'd0);
    @(negedge clk_i);
    mig_wready = 1'b0;
    wr_valid_i = 1'b0;
    #1;
    chk("w_wlast_resp", 64'(mig_wlast), 64'd0);
    chk("w_bready", 64'(mig_bready), 64'd1);
    chk("w_done_wait", 64'(done_o), 64'd0);
    @(negedge clk_i);
    mig_bvalid = 1'b1;
    #1 chk("w_done", 64'(done_o), 64'b100);
    @(negedge clk_i);
    mig_bvalid = 1'b0;
    #1 chk("w_done_off", 64'(done_o), 64'd0);
    req_valid_i = 3'b010;
    req_len_i[1] = 8'd0;
    txn(1, 0, 0, 1'b0);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    req_len_i = {8'd1, 8'd1, 8'd1};
    req_valid_i = 3'b111;
    txn(0, 1, 0, 1'b1);
    txn(1, 1, 0, 1'b1);
    txn(2, 1, 0, 1'b1);
    txn(0, 1, 0, 1'b1);
    req_valid_i = 3'b001;
    req_len_i[0] = 8'd4;
    #1 chk("r_grant", 64'(req_ready_o), 64'b001);
    @(negedge clk_i);
    req_valid_i = 3'b000;
    mig_arready = 1'b1;
    @(negedge clk_i);
    mig_arready = 1'b0;
    mig_data_valid = 1'b1;
    @(negedge clk_i);
    #1 chk("r_beat2", 64'(rd_valid_o), 64'b01);
    reset_i = 1'b1;
    #1;
    chk("r_rst_valid", 64'(rd_valid_o), 64'd0);
    chk("r_rst_done", 64'(done_o), 64'd0);
    chk("r_rst_addr", 64'(mig_addr), 64'd0);
    chk("r_rst_arwlen", 64'(mig_arwlen), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    mig_data_valid = 1'b0;
    req_valid_i = 3'b010;
    req_len_i[1] = 8'd2;
    txn(1, 2, 1, 1'b0);
    req_valid_i = 3'b011;
    req_len_i = {8'd1, 8'd1, 8'd1};
    #1 chk("t_grant", 64'(req_ready_o), 64'b001);
    @(negedge clk_i);
    req_valid_i = 3'b010;
    for (int k = 2; k <= 16; k++) @(negedge clk_i);
    #1;
`ifdef MIG_ARB_TIMEOUT_EN
    chk("t_err", 64'(err_o), 64'd1);
    chk("t_arvalid", 64'(mig_arvalid), 64'd0);
    chk("t_done", 64'(done_o), 64'd0);
    @(negedge clk_i);
    #1 chk("t_next_grant", 64'(req_ready_o), 64'b010);
`else
    chk("t_no_err", 64'(err_o), 64'd0);
    chk("t_arvalid_held", 64'(mig_arvalid), 64'd1);
    mig_arready = 1'b1;
    @(negedge clk_i);
    mig_arready = 1'b0;
    mig_data_valid = 1'b1;
    mig_rw_last = 1'b1;
    #1 chk("t_done", 64'(done_o), 64'b001);
    @(negedge clk_i);
    mig_data_valid = 1'b0;
    mig_rw_last = 1'b0;
    #1 chk("t_next_grant", 64'(req_ready_o), 64'b010);
`endif
    req_valid_i = 3'b000;
    @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
